// File: rtl/sync_detect_module.sv
// sync_detect_module: VGA sync receiver that measures line/frame timing, locks, and regenerates pixel addresses
module sync_detect_module #(
    parameter int H_SYN       = 32,
    parameter int H_BKPORCH   = 80,
    parameter int H_DATA      = 1440,
    parameter int H_TOTAL     = 1600,
    parameter int V_SYN       = 6,
    parameter int V_BKPORCH   = 17,
    parameter int V_DATA      = 900,
    parameter int V_TOTAL     = 926,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        HSYNC_Sig,
    input  logic        VSYNC_Sig,
    output logic        Ready_Sig,
    output logic [10:0] Column_Addr_Sig,
    output logic [10:0] Row_Addr_Sig,
    output logic        Locked_Sig,
    output logic        Error_Sig,
    output logic        Frame_Start_Sig,
    output logic [10:0] H_Total_Meas,
    output logic [10:0] V_Total_Meas
);
    localparam logic [10:0] H_A0   = 11'(H_SYN + H_BKPORCH);
    localparam logic [10:0] H_A1   = 11'(H_SYN + H_BKPORCH + H_DATA);
    localparam logic [10:0] V_A0   = 11'(V_SYN + V_BKPORCH);
    localparam logic [10:0] V_A1   = 11'(V_SYN + V_BKPORCH + V_DATA);
    localparam logic [11:0] H_TOT  = 12'(H_TOTAL);
    localparam logic [11:0] V_TOT  = 12'(V_TOTAL);
    localparam logic [11:0] H_SW   = 12'(H_SYN);
    localparam logic [2:0]  LOCK_N = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t      state_q;
    logic        hs_q, vs_q, h_seen_q, v_seen_q, hsw_ok_q, line_bad_q, error_q, frame_start_q;
    logic [10:0] count_h_q, count_h_d, count_v_q, count_v_d, h_meas_q, v_meas_q;
    logic [2:0]  good_cnt_q;
    logic        hs_fall, hs_rise, vs_fall, h_sat, v_sat;
    logic        line_chk, line_bad, frame_chk, frame_good, frame_bad;
    logic [11:0] h_len, v_len;
    logic [10:0] h_cand, v_cand;

    always_comb begin
        hs_fall    = hs_q & ~HSYNC_Sig;
        hs_rise    = ~hs_q & HSYNC_Sig;
        vs_fall    = vs_q & ~VSYNC_Sig;
        h_sat      = &count_h_q;
        v_sat      = &count_v_q;
        h_len      = {1'b0, count_h_q} + 12'd1;
        v_len      = {1'b0, count_v_q} + 12'd1;
        h_cand     = h_sat ? count_h_q : h_len[10:0];
        v_cand     = v_sat ? count_v_q : v_len[10:0];
        line_chk   = hs_fall & h_seen_q;
        line_bad   = line_chk & ((h_len != H_TOT) | ~hsw_ok_q);
        frame_chk  = vs_fall & v_seen_q;
        frame_good = frame_chk & (v_len == V_TOT) & ~line_bad_q & ~line_bad;
        frame_bad  = frame_chk & ~frame_good;
        count_h_d  = hs_fall ? '0 : h_sat ? count_h_q : count_h_q + 11'd1;
        count_v_d  = vs_fall ? '0 : (hs_fall & ~v_sat) ? count_v_q + 11'd1 : count_v_q;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= SEARCH;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            hsw_ok_q      <= 1'b0;
            line_bad_q    <= 1'b0;
            error_q       <= 1'b0;
            frame_start_q <= 1'b0;
            count_h_q     <= '0;
            count_v_q     <= '0;
            h_meas_q      <= '0;
            v_meas_q      <= '0;
            good_cnt_q    <= '0;
        end else begin
            hs_q          <= HSYNC_Sig;
            vs_q          <= VSYNC_Sig;
            count_h_q     <= count_h_d;
            count_v_q     <= count_v_d;
            frame_start_q <= vs_fall;
            error_q       <= 1'b0;
            if (hs_fall) h_seen_q <= 1'b1;
            if (vs_fall) v_seen_q <= 1'b1;
            if (line_chk) h_meas_q <= h_cand;
            if (frame_chk) v_meas_q <= v_cand;
            if (hs_rise) hsw_ok_q <= (h_len == H_SW);
            // A bad line on the closing hs_fall is already folded into this frame's check
            line_bad_q <= vs_fall ? 1'b0 : (line_bad_q | line_bad);
            case (state_q)
                SEARCH: begin
                    if (frame_good) begin
                        state_q    <= (LOCK_N == 3'd1) ? LOCKED : CHECK;
                        good_cnt_q <= 3'd1;
                    end
                end
                CHECK: begin
                    if (frame_bad | line_bad) begin
                        state_q    <= SEARCH;
                        good_cnt_q <= '0;
                    end else if (frame_good) begin
                        good_cnt_q <= good_cnt_q + 3'd1;
                        if (good_cnt_q + 3'd1 == LOCK_N) state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (line_bad | frame_bad | h_sat | v_sat) begin
                        state_q    <= SEARCH;
                        good_cnt_q <= '0;
                        error_q    <= 1'b1;
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    assign Locked_Sig      = (state_q == LOCKED);
    assign Error_Sig       = error_q;
    assign Frame_Start_Sig = frame_start_q;
    assign H_Total_Meas    = h_meas_q;
    assign V_Total_Meas    = v_meas_q;
    assign Ready_Sig       = Locked_Sig & (count_h_q >= H_A0) & (count_h_q < H_A1)
                           & (count_v_q >= V_A0) & (count_v_q < V_A1);
    assign Column_Addr_Sig = Ready_Sig ? count_h_q - H_A0 : '0;
    assign Row_Addr_Sig    = Ready_Sig ? count_v_q - V_A0 : '0;
endmodule

// File: tb/tb_sync_detect_module.sv
// tb_sync_detect_module: directed bench with a scaled-down sync generator driving sync_detect_module
module tb_sync_detect_module;
    localparam int HS = 4, HB = 6, HD = 20, HT = 40, VS = 2, VB = 3, VD = 10, VT = 20;

    logic        clk = 1'b0;
    logic        rst_n, hsync, vsync, ready, locked, error, frame_start;
    logic [10:0] col, row, h_meas, v_meas;
    int          n_chk = 0, n_fail = 0;
    int          hc, vc, h_tot = HT, h_syn = HS, v_tot = VT, v_syn = VS, extra = 0, vs_cnt = 0;
    logic        hold = 1'b0, prev_vs = 1'b1;
    int          exp_rdy, exp_col, exp_row;
    int          err_acc = 0, rdy_acc = 0, lck_acc = 0, fs_acc = 0;

    always #5 clk = ~clk;

    sync_detect_module #(
        .H_SYN(HS), .H_BKPORCH(HB), .H_DATA(HD), .H_TOTAL(HT),
        .V_SYN(VS), .V_BKPORCH(VB), .V_DATA(VD), .V_TOTAL(VT), .LOCK_FRAMES(2)
    ) dut (
        .CLK(clk),
        .RSTn(rst_n),
        .HSYNC_Sig(hsync),
        .VSYNC_Sig(vsync),
        .Ready_Sig(ready),
        .Column_Addr_Sig(col),
        .Row_Addr_Sig(row),
        .Locked_Sig(locked),
        .Error_Sig(error),
        .Frame_Start_Sig(frame_start),
        .H_Total_Meas(h_meas),
        .V_Total_Meas(v_meas)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Outputs after this edge reflect the previously driven position, i.e. the transmitter delayed by 1
    task automatic tick();
        @(posedge clk);
        #1;
        err_acc += int'(error);
        rdy_acc += int'(ready);
        lck_acc += int'(locked);
        fs_acc  += int'(frame_start);
        exp_rdy = (hc >= HS + HB && hc < HS + HB + HD && vc >= VS + VB && vc < VS + VB + VD) ? 1 : 0;
        exp_col = exp_rdy != 0 ? hc - (HS + HB) : 0;
        exp_row = exp_rdy != 0 ? vc - (VS + VB) : 0;
        if (hc >= h_tot - 1 + extra) begin
            hc    = 0;
            extra = 0;
            vc    = (vc >= v_tot - 1) ? 0 : vc + 1;
        end else hc++;
        hsync = hold | (hc >= h_syn);
        vsync = hold | (vc >= v_syn);
        if (prev_vs && !vsync) vs_cnt++;
        prev_vs = vsync;
    endtask

    task automatic run_to_vs(input int target);
        int n = 0;
        while (vs_cnt < target && n < 4000) begin
            tick();
            n++;
        end
        if (vs_cnt < target) check("vs_timeout", vs_cnt, target);
    endtask

    task automatic expect_relock(input int base, input string tag);
        run_to_vs(base + 2);
        tick();
        check({tag, "_prelock2"}, locked, 0);
        run_to_vs(base + 3);
        check({tag, "_prelock3"}, locked, 0);
        tick();
        check({tag, "_lock"}, locked, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_col"}, col, 0);
        check({tag, "_row"}, row, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_fs"}, frame_start, 0);
        check({tag, "_hmeas"}, h_meas, 0);
        check({tag, "_vmeas"}, v_meas, 0);
    endtask

    initial begin
        int n, base;
        rst_n = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        hc    = HT - 1;
        vc    = VT - 1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        // T1: acquire lock on the 3rd vs_fall
        run_to_vs(1);
        tick();
        check("t1_fs_pulse", frame_start, 1);
        check("t1_hmeas_first", h_meas, 0);
        check("t1_vmeas_first", v_meas, 0);
        check("t1_locked_vs1", locked, 0);
        tick();
        check("t1_fs_clear", frame_start, 0);
        run_to_vs(2);
        tick();
        check("t1_vmeas", v_meas, VT);
        check("t1_hmeas", h_meas, HT);
        check("t1_locked_vs2", locked, 0);
        run_to_vs(3);
        check("t1_locked_pre", locked, 0);
        tick();
        check("t1_locked", locked, 1);
        check("t1_error", error, 0);
        // T2: regenerated window over one full frame
        rdy_acc = 0;
        fs_acc  = 0;
        repeat (HT * VT) begin
            tick();
            check("t2_ready", ready, exp_rdy);
            check("t2_col", col, exp_col);
            check("t2_row", row, exp_row);
        end
        check("t2_ready_cnt", rdy_acc, HD * VD);
        check("t2_fs_cnt", fs_acc, 1);
        // T3: one line stretched by a clock
        n = 0;
        while (hc != 15 && n < 100) begin
            tick();
            n++;
        end
        base    = vs_cnt;
        err_acc = 0;
        extra   = 1;
        repeat (2 * HT) tick();
        check("t3_error_cnt", err_acc, 1);
        check("t3_unlocked", locked, 0);
        rdy_acc = 0;
        expect_relock(base, "t3");
        check("t3_ready_dark", rdy_acc, 0);
        check("t3_error_once", err_acc, 1);
        // T4: both syncs stuck high until Count_H saturates
        err_acc = 0;
        hold    = 1'b1;
        repeat (3000) tick();
        check("t4_error_cnt", err_acc, 1);
        check("t4_unlocked", locked, 0);
        check("t4_hmeas_kept", h_meas, HT);
        hold = 1'b0;
        base = vs_cnt;
        expect_relock(base, "t4");
        // T5: foreign timing never locks
        base    = vs_cnt;
        err_acc = 0;
        h_tot   = 52;
        h_syn   = 6;
        v_tot   = 17;
        run_to_vs(base + 1);
        lck_acc = 0;
        run_to_vs(base + 5);
        tick();
        check("t5_never_locked", lck_acc, 0);
        check("t5_error_cnt", err_acc, 1);
        check("t5_hmeas", h_meas, 52);
        check("t5_vmeas", v_meas, 17);
        n = 0;
        while (hc != 20 && n < 100) begin
            tick();
            n++;
        end
        h_tot = HT;
        h_syn = HS;
        v_tot = VT;
        base  = vs_cnt;
        expect_relock(base, "t5r");
        // T6: asynchronous reset mid-frame while locked
        n = 0;
        while (exp_rdy == 0 && n < 400) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check("t6_pre_ready", ready, exp_rdy);
        check("t6_pre_col", col, exp_col);
        rst_n = 1'b0;
        #1;
        check_zero("t6_async");
        repeat (5) tick();
        check_zero("t6_held");
        rst_n = 1'b1;
        base  = vs_cnt;
        expect_relock(base, "t6");
        tick();
        check("t6_hmeas", h_meas, HT);
        check("t6_vmeas", v_meas, VT);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
